// File: rtl/transmission8_pkg.sv
// transmission8_pkg: shared widths, frame length and FSM state type for the
// 8-bit transmission channel (transmitter and receiver sides).
// Build option: define PARITY_EN to add an even-parity bit after D0.
package transmission8_pkg;

  localparam int unsigned SEL_W   = 3;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned FRAME_W = SEL_W + DATA_W;

  // Bits between start and stop: A,B,C, D7..D0 and the optional parity bit.
`ifdef PARITY_EN
  localparam int unsigned FRAME_BITS = 12;
`else
  localparam int unsigned FRAME_BITS = 11;
`endif

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    ADDR   = 3'd2,
    DATA   = 3'd3,
    PARITY = 3'd4,
    STOP   = 3'd5
  } rx_state_e;

endpackage

// File: rtl/transmission8_sync.sv
// transmission8_sync: two-flop synchronizer for an asynchronous single-bit input.
// Ports:
//   iClk  - system clock
//   iRst  - asynchronous active-high reset (both flops load RST_VAL)
//   iD    - asynchronous input
//   oQ    - synchronized output, two cycles of latency
module transmission8_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic iClk,
  input  logic iRst,
  input  logic iD,
  output logic oQ
);

  logic meta_q;
  logic sync_q;

  // Metastability filter chain.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= iD;
      sync_q <= meta_q;
    end
  end

  assign oQ = sync_q;

endmodule

// File: rtl/transmission8_rx.sv
// transmission8_rx: receive end of the 8-bit transmission channel.
// Deserializes start, A,B,C, D7..D0, [parity], stop from a single idle-high
// wire and presents each good frame as parallel data with a one-cycle strobe.
// Build option: define PARITY_EN to expect an even-parity bit after D0.
// Ports:
//   iClk      - system clock, rising edge
//   iRst      - asynchronous active-high reset
//   iSer      - serial line, idles high, asynchronous to iClk
//   oData     - payload of the last good frame
//   oA/oB/oC  - channel select bits of the last good frame (A is MSB)
//   oValid    - one-cycle pulse, outputs updated
//   oFrameErr - one-cycle pulse, frame rejected
//   oBusy     - high from start-bit confirmation until return to IDLE
module transmission8_rx
  import transmission8_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned DATA_W       = 8
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iSer,
  output logic [DATA_W-1:0] oData,
  output logic              oA,
  output logic              oB,
  output logic              oC,
  output logic              oValid,
  output logic              oFrameErr,
  output logic              oBusy
);

  localparam int unsigned CNT_W  = $clog2(CLKS_PER_BIT);
  localparam int unsigned BIT_W  = $clog2(FRAME_BITS);
  localparam int unsigned SH_W   = SEL_W + DATA_W;
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic ser_s;

  rx_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic [BIT_W-1:0]  bit_q,   bit_d;
  logic [SH_W-1:0]   sh_q,    sh_d;
  logic [DATA_W-1:0] data_q,  data_d;
  logic [SEL_W-1:0]  sel_q,   sel_d;
  logic              valid_q, valid_d;
  logic              err_q,   err_d;
  logic              busy_q,  busy_d;
  logic              rearm_q, rearm_d;
`ifdef PARITY_EN
  logic              par_q,   par_d;
  logic              perr_q,  perr_d;
`endif
  logic              mid;
  logic              frame_ok;

  transmission8_sync #(
    .RST_VAL(1'b1)
  ) u_sync (
    .iClk(iClk),
    .iRst(iRst),
    .iD  (iSer),
    .oQ  (ser_s)
  );

  // State and datapath registers.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      rearm_q <= 1'b1;
`ifdef PARITY_EN
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      rearm_q <= rearm_d;
`ifdef PARITY_EN
      par_q   <= par_d;
      perr_q  <= perr_d;
`endif
    end
  end

  assign mid = (cnt_q == CNT_MID);

`ifdef PARITY_EN
  assign frame_ok = ser_s & ~perr_q;
`else
  assign frame_ok = ser_s;
`endif

  // Next-state and output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
    bit_d   = bit_q;
    sh_d    = sh_q;
    data_d  = data_q;
    sel_d   = sel_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    busy_d  = busy_q;
    rearm_d = rearm_q;
`ifdef PARITY_EN
    par_d   = par_q;
    perr_d  = perr_q;
`endif

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        bit_d = '0;
`ifdef PARITY_EN
        par_d  = 1'b0;
        perr_d = 1'b0;
`endif
        // After an error the line must be seen high before a new start counts.
        if (ser_s) begin
          rearm_d = 1'b1;
        end else if (rearm_q) begin
          state_d = START;
        end
      end

      START: begin
        if (mid) begin
          if (!ser_s) begin
            busy_d  = 1'b1;
            state_d = ADDR;
          end else begin
            state_d = IDLE;
          end
        end
      end

      ADDR: begin
        if (mid) begin
          sh_d = {sh_q[SH_W-2:0], ser_s};
`ifdef PARITY_EN
          par_d = par_q ^ ser_s;
`endif
          if (bit_q == BIT_W'(SEL_W - 1)) begin
            bit_d   = '0;
            state_d = DATA;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end

      DATA: begin
        if (mid) begin
          sh_d = {sh_q[SH_W-2:0], ser_s};
`ifdef PARITY_EN
          par_d = par_q ^ ser_s;
`endif
          if (bit_q == BIT_W'(DATA_W - 1)) begin
            bit_d = '0;
`ifdef PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end

      PARITY: begin
`ifdef PARITY_EN
        // Even parity: received bit must match the running XOR.
        if (mid) begin
          perr_d  = par_q ^ ser_s;
          state_d = STOP;
        end
`else
        state_d = IDLE;
`endif
      end

      STOP: begin
        if (mid) begin
          busy_d  = 1'b0;
          state_d = IDLE;
          if (frame_ok) begin
            valid_d = 1'b1;
            sel_d   = sh_q[SH_W-1:DATA_W];
            data_d  = sh_q[DATA_W-1:0];
          end else begin
            err_d   = 1'b1;
            rearm_d = 1'b0;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign oData     = data_q;
  assign oA        = sel_q[2];
  assign oB        = sel_q[1];
  assign oC        = sel_q[0];
  assign oValid    = valid_q;
  assign oFrameErr = err_q;
  assign oBusy     = busy_q;

endmodule

// File: tb/tb_transmission8_rx.sv
// tb_transmission8_rx: randomized scoreboard bench for transmission8_rx with
// CLKS_PER_BIT=4. Build option PARITY_EN must match the DUT build.
module tb_transmission8_rx;

  localparam int CPB = 4;
`ifdef PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic       iClk = 1'b0;
  logic       iRst;
  logic       iSer;
  logic [7:0] oData;
  logic       oA, oB, oC;
  logic       oValid, oFrameErr, oBusy;

  transmission8_rx #(
    .CLKS_PER_BIT(CPB),
    .DATA_W      (8)
  ) dut (
    .iClk     (iClk),
    .iRst     (iRst),
    .iSer     (iSer),
    .oData    (oData),
    .oA       (oA),
    .oB       (oB),
    .oC       (oC),
    .oValid   (oValid),
    .oFrameErr(oFrameErr),
    .oBusy    (oBusy)
  );

  always #5 iClk = ~iClk;

  int cyc = 0;
  always @(posedge iClk) cyc <= cyc + 1;

  typedef struct {
    bit         is_err;
    logic [2:0] sel;
    logic [7:0] data;
    int         stop_cyc;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  logic [2:0] last_sel  = '0;
  logic [7:0] last_data = '0;
  int         tests = 0;
  int         fails = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: every pulse must match the oldest expected frame outcome.
  always @(negedge iClk) begin
    if (iRst === 1'b0) begin
      if (oValid && oFrameErr) check("valid_err_overlap", 1, 0);
      if (oValid || oFrameErr) begin
        if (sb.size() == 0) begin
          check("unexpected_pulse", {30'd0, oValid, oFrameErr}, 0);
        end else begin
          mon_e = sb.pop_front();
          check("pulse_kind_err", 32'(oFrameErr), 32'(mon_e.is_err));
          check("pulse_data", 32'(oData), 32'(mon_e.data));
          check("pulse_sel", 32'({oA, oB, oC}), 32'(mon_e.sel));
          check("pulse_latency_window",
                ((cyc - mon_e.stop_cyc) >= 3 && (cyc - mon_e.stop_cyc) <= 6) ? 1 : 0, 1);
        end
      end
    end
  end

  task automatic drive_bit(input logic b);
    iSer = b;
    repeat (CPB) @(posedge iClk);
    #1;
  endtask

  task automatic send_frame(input logic [2:0] sel, input logic [7:0] data,
                            input bit bad_stop, input bit bad_par);
    logic [10:0] bits;
    exp_t        e;
    bits = {sel, data};
    drive_bit(1'b0);
    for (int i = 10; i >= 0; i--) begin
      drive_bit(bits[i]);
      if (i == 8) check("busy_in_frame", 32'(oBusy), 1);
    end
    if (PAR) drive_bit((^bits) ^ bad_par);
    e.stop_cyc = cyc;
    if (!bad_stop && !(PAR && bad_par)) begin
      e.is_err  = 1'b0;
      e.sel     = sel;
      e.data    = data;
      last_sel  = sel;
      last_data = data;
    end else begin
      e.is_err = 1'b1;
      e.sel    = last_sel;
      e.data   = last_data;
    end
    sb.push_back(e);
    drive_bit(!bad_stop);
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && sb.size() != 0; i++) @(posedge iClk);
    #1;
    check("drain_queue_empty", 32'(sb.size()), 0);
    drive_bit(1'b1);
    check("hold_data", 32'(oData), 32'(last_data));
    check("hold_sel", 32'({oA, oB, oC}), 32'(last_sel));
  endtask

  task automatic check_reset_outputs(input string nm);
    check({nm, "_data"}, 32'(oData), 0);
    check({nm, "_sel"}, 32'({oA, oB, oC}), 0);
    check({nm, "_pulses"}, 32'({oValid, oFrameErr}), 0);
    check({nm, "_busy"}, 32'(oBusy), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit   busy_seen;
    exp_t e;
    iRst = 1'b1;
    iSer = 1'b1;
    repeat (3) @(posedge iClk);
    #1;
    check_reset_outputs("reset_held");
    iRst = 1'b0;
    repeat (5) drive_bit(1'b1);
    check_reset_outputs("reset_released");

    // Single frame.
    send_frame(3'b101, 8'hFF, 1'b0, 1'b0);
    drain();

    // One-cycle glitch on an idle line.
    busy_seen = 1'b0;
    iSer = 1'b0;
    @(posedge iClk); #1;
    iSer = 1'b1;
    for (int i = 0; i < 6 * CPB; i++) begin
      @(posedge iClk); #1;
      if (oBusy) busy_seen = 1'b1;
    end
    check("glitch_no_busy", 32'(busy_seen), 0);
    check("glitch_queue_empty", 32'(sb.size()), 0);

    // Bad stop bit keeps the previous frame.
    send_frame(3'b011, 8'hA5, 1'b1, 1'b0);
    drive_bit(1'b1);
    drain();

    // Back-to-back frames with no idle gap.
    send_frame(3'b000, 8'h3C, 1'b0, 1'b0);
    send_frame(3'b111, 8'hC3, 1'b0, 1'b0);
    drain();

    // Line stuck low: error, then wait for the line to return high.
    drive_bit(1'b0);
    for (int i = 0; i < 11 + int'(PAR); i++) drive_bit(1'b0);
    e.is_err   = 1'b1;
    e.sel      = last_sel;
    e.data     = last_data;
    e.stop_cyc = cyc;
    sb.push_back(e);
    repeat (8) drive_bit(1'b0);
    repeat (2) drive_bit(1'b1);
    drain();
    send_frame(3'b010, 8'h5A, 1'b0, 1'b0);
    drain();

`ifdef PARITY_EN
    send_frame(3'b101, 8'h01, 1'b0, 1'b1);
    drain();
`endif

    // Randomized traffic.
    for (int n = 0; n < 24; n++) begin
      logic [2:0] s;
      logic [7:0] d;
      bit         bs, bp;
      int         gap;
      s   = 3'($urandom_range(0, 7));
      d   = 8'($urandom_range(0, 255));
      bs  = ($urandom_range(0, 4) == 0);
      bp  = PAR && ($urandom_range(0, 4) == 0);
      gap = int'($urandom_range(0, 2)) + (bs ? 1 : 0);
      send_frame(s, d, bs, bp);
      repeat (gap) drive_bit(1'b1);
    end
    drain();

    // Reset asserted during the DATA bits abandons the frame.
    send_frame(3'b111, 8'hC3, 1'b0, 1'b0);
    drain();
    drive_bit(1'b0);
    drive_bit(1'b1); drive_bit(1'b0); drive_bit(1'b1);
    drive_bit(1'b1); drive_bit(1'b0);
    iRst = 1'b1;
    #2;
    check_reset_outputs("reset_mid_frame");
    iSer = 1'b1;
    repeat (3) @(posedge iClk);
    #1;
    iRst = 1'b0;
    sb.delete();
    last_sel  = '0;
    last_data = '0;
    repeat (20) drive_bit(1'b1);
    check_reset_outputs("after_mid_reset");

    // Recovery after reset.
    send_frame(3'b110, 8'h81, 1'b0, 1'b0);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
